// File: rtl/tinker_mem_pkg.sv
// rtl/tinker_mem_pkg.sv - shared types and helpers for the Tinker memory responder
// Purpose: FSM state enum, access-size encodings, default array size,
//          captured request struct and the address range check.
// Ports:   none (package)
package tinker_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic SZ_WORD  = 1'b0;
  localparam logic SZ_DWORD = 1'b1;

  localparam int unsigned DEF_MEM_BYTES = 524288;

  // The captured tag is stored at a fixed maximum width so the struct can
  // live in the package; the responder uses only the low ID_W bits.
  localparam int unsigned REQ_ID_MAX_W = 16;

  typedef struct packed {
    logic                    we;
    logic                    size;
    logic [63:0]             addr;
    logic [63:0]             wdata;
    logic [REQ_ID_MAX_W-1:0] id;
  } mem_req_t;

  function automatic logic [7:0] size_byte_en(input logic size);
    return (size == SZ_DWORD) ? 8'hFF : 8'h0F;
  endfunction

  // The last touched byte is formed in 65 bits so an access that wraps past
  // 2^64 lands above the array instead of aliasing to a low address.
  function automatic logic out_of_range(input logic [63:0] addr, input logic size,
                                        input int unsigned mem_bytes);
    logic [64:0] last;
    last = {1'b0, addr} + ((size == SZ_DWORD) ? 65'd7 : 65'd3);
    return last >= 65'(mem_bytes);
  endfunction

endpackage

// File: rtl/tinker_mem_responder_if.sv
// rtl/tinker_mem_responder_if.sv - request/response channel between core and memory responder
// Purpose: groups the valid/ready request channel and the valid/ready
//          response channel.
// Ports (signals):
//   req_valid, req_ready, req_we, req_size, req_addr[63:0], req_wdata[63:0],
//   req_id[ID_W-1:0], rsp_valid, rsp_ready, rsp_rdata[63:0], rsp_id[ID_W-1:0],
//   rsp_err
// Modports: master (requester / core side), slave (responder side)
interface tinker_mem_if #(
  parameter int unsigned ID_W = 4
);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic            req_size;
  logic [63:0]     req_addr;
  logic [63:0]     req_wdata;
  logic [ID_W-1:0] req_id;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [63:0]     rsp_rdata;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, req_id, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, req_id, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_id, rsp_err
  );

endinterface

// File: rtl/tinker_byte_ram.sv
// rtl/tinker_byte_ram.sv - byte array with an 8-byte read port and byte-enabled write port
// Purpose: backing store for the memory responder; contents are not reset.
// Ports:
//   clk            in   clock
//   rd_addr        in   address of the lowest byte read
//   rd_data[63:0]  out  {mem[rd_addr+7] .. mem[rd_addr]}, combinational
//   wr_en          in   write strobe
//   wr_addr        in   address of the lowest byte written
//   wr_be[7:0]     in   per-byte enables, bit k covers wr_data[8k+7:8k]
//   wr_data[63:0]  in   write data, little-endian
module tinker_byte_ram
  import tinker_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [63:0]       rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_be,
  input  logic [63:0]       wr_data
);

  logic [7:0] mem [MEM_BYTES];

  // Byte indices wrap within the array; lanes past the top only matter for
  // accesses the responder has already flagged or masked off.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 8; k++) begin
      rd_data[8*k +: 8] = mem[rd_addr + ADDR_W'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr + ADDR_W'(k)] <= wr_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/tinker_mem_responder.sv
// rtl/tinker_mem_responder.sv - fixed-latency memory responder for fetches, loads and stores
// Purpose: accepts one request at a time, waits LATENCY cycles, commits the
//          access to the byte array and holds the response until taken.
// Ports:
//   clk    in     clock
//   reset  in     asynchronous, active-high reset
//   bus    slave  request/response channel (tinker_mem_if)
module tinker_mem_responder
  import tinker_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ID_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  tinker_mem_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q;
  mem_req_t         req_in;
  mem_req_t         acc_req;
  logic             accept;
  logic             commit;
  logic             acc_err;
  logic [63:0]      ram_rdata;
  logic [63:0]      commit_rdata;
  logic [63:0]      rsp_rdata_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             rsp_err_q;

  always_comb begin
    req_in       = '0;
    req_in.we    = bus.req_we;
    req_in.size  = bus.req_size;
    req_in.addr  = bus.req_addr;
    req_in.wdata = bus.req_wdata;
    req_in.id    = REQ_ID_MAX_W'(bus.req_id);
  end

  assign accept = (state_q == IDLE) && bus.req_valid;

  // With LATENCY == 0 the access commits on the accepting edge, so the
  // commit path reads the live request rather than the captured one.
  assign acc_req = (state_q == IDLE) ? req_in : req_q;
  assign acc_err = out_of_range(acc_req.addr, acc_req.size, MEM_BYTES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(LAT_M1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    commit_rdata = '0;
    if (!acc_err && !acc_req.we) begin
      commit_rdata = (acc_req.size == SZ_DWORD) ? ram_rdata : {32'b0, ram_rdata[31:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= req_in;
      end
      if (commit) begin
        rsp_rdata_q <= commit_rdata;
        rsp_id_q    <= acc_req.id[ID_W-1:0];
        rsp_err_q   <= acc_err;
      end
    end
  end

  // The RAM write port is not reset, so a held reset must also block the
  // zero-latency commit path that is otherwise open in IDLE.
  tinker_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rd_addr (acc_req.addr[ADDR_W-1:0]),
    .rd_data (ram_rdata),
    .wr_en   (commit && !reset && acc_req.we && !acc_err),
    .wr_addr (acc_req.addr[ADDR_W-1:0]),
    .wr_be   (size_byte_en(acc_req.size)),
    .wr_data (acc_req.wdata)
  );

  logic unused_id_hi;
  assign unused_id_hi = ^(acc_req.id >> ID_W);

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// tb/tb_tinker_mem_responder.sv - scoreboard bench for tinker_mem_responder
// Purpose: drives three responders (LATENCY 2, 3 and 0) through a shared
//          requester; expected responses come from a byte model.
// Ports:   none
module tb_tinker_mem_responder;

  localparam int unsigned MEM_BYTES = 524288;

  typedef struct packed {
    logic [63:0] rdata;
    logic [3:0]  id;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerrors = 0;

  logic rst2, rst3, rst0;
  int   sel;

  logic        req_valid, req_we, req_size, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_id;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [3:0]  rsp_id;

  exp_t       sb [$];
  logic [7:0] model [longint];

  tinker_mem_if #(.ID_W(4)) b2 ();
  tinker_mem_if #(.ID_W(4)) b3 ();
  tinker_mem_if #(.ID_W(4)) b0 ();

  assign b2.req_valid = (sel == 0) && req_valid;
  assign b3.req_valid = (sel == 1) && req_valid;
  assign b0.req_valid = (sel == 2) && req_valid;
  assign b2.rsp_ready = (sel == 0) && rsp_ready;
  assign b3.rsp_ready = (sel == 1) && rsp_ready;
  assign b0.rsp_ready = (sel == 2) && rsp_ready;
  assign b2.req_we = req_we;       assign b3.req_we = req_we;       assign b0.req_we = req_we;
  assign b2.req_size = req_size;   assign b3.req_size = req_size;   assign b0.req_size = req_size;
  assign b2.req_addr = req_addr;   assign b3.req_addr = req_addr;   assign b0.req_addr = req_addr;
  assign b2.req_wdata = req_wdata; assign b3.req_wdata = req_wdata; assign b0.req_wdata = req_wdata;
  assign b2.req_id = req_id;       assign b3.req_id = req_id;       assign b0.req_id = req_id;

  assign req_ready = (sel == 0) ? b2.req_ready : (sel == 1) ? b3.req_ready : b0.req_ready;
  assign rsp_valid = (sel == 0) ? b2.rsp_valid : (sel == 1) ? b3.rsp_valid : b0.rsp_valid;
  assign rsp_rdata = (sel == 0) ? b2.rsp_rdata : (sel == 1) ? b3.rsp_rdata : b0.rsp_rdata;
  assign rsp_id    = (sel == 0) ? b2.rsp_id    : (sel == 1) ? b3.rsp_id    : b0.rsp_id;
  assign rsp_err   = (sel == 0) ? b2.rsp_err   : (sel == 1) ? b3.rsp_err   : b0.rsp_err;

  tinker_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(2), .ID_W(4)) u_l2 (
    .clk(clk), .reset(rst2), .bus(b2));
  tinker_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(3), .ID_W(4)) u_l3 (
    .clk(clk), .reset(rst3), .bus(b3));
  tinker_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(0), .ID_W(4)) u_l0 (
    .clk(clk), .reset(rst0), .bus(b0));

  function automatic int lat_now();
    return (sel == 0) ? 3 : (sel == 1) ? 4 : 1;
  endfunction

  // Byte model keyed by instance so the three arrays stay independent.
  function automatic exp_t model_rsp(input logic we, input logic size, input logic [63:0] addr,
                                     input logic [63:0] wdata, input logic [3:0] id, input int acc);
    exp_t        e;
    logic [64:0] last;
    longint      key;
    int          nb;
    nb      = size ? 8 : 4;
    last    = {1'b0, addr} + 65'(nb - 1);
    e.id    = id;
    e.acc   = acc;
    e.err   = (last >= 65'(MEM_BYTES));
    e.rdata = '0;
    if (!e.err) begin
      for (int k = 0; k < nb; k++) begin
        key = (longint'(sel) << 40) | longint'(addr + 64'(k));
        if (we) model[key] = wdata[8*k +: 8];
        else e.rdata[8*k +: 8] = model.exists(key) ? model[key] : 8'h00;
      end
    end
    return e;
  endfunction

  task automatic send(input logic we, input logic size, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [3:0] id, output int acc);
    int n;
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata; req_id = id;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    nchecks++;
    if (req_ready !== 1'b1) begin
      nerrors++;
      $display("FAIL accept_timeout id=%0d: req_ready=%b, required 1", id, req_ready);
      acc = -1;
      req_valid = 1'b0;
    end else begin
      acc = cyc;
      sb.push_back(model_rsp(we, size, addr, wdata, id, acc));
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic recv(input int stall, output int hs, output logic [63:0] rd, output logic er);
    int   n;
    exp_t e;
    hs = -1; rd = '1; er = 1'bx;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    nchecks++;
    if (rsp_valid !== 1'b1) begin
      nerrors++;
      $display("FAIL rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
      return;
    end
    nchecks++;
    if (sb.size() == 0) begin
      nerrors++;
      $display("FAIL rsp_unexpected: id=%0d, required no response", rsp_id);
      return;
    end
    e = sb.pop_front();
    nchecks++;
    if (cyc - e.acc != lat_now()) begin
      nerrors++;
      $display("FAIL rsp_latency id=%0d: %0d cycles, required %0d", e.id, cyc - e.acc, lat_now());
    end
    nchecks++;
    if (rsp_rdata !== e.rdata) begin
      nerrors++;
      $display("FAIL rsp_rdata id=%0d: %h, required %h", e.id, rsp_rdata, e.rdata);
    end
    nchecks++;
    if (rsp_id !== e.id) begin
      nerrors++;
      $display("FAIL rsp_id: %0d, required %0d", rsp_id, e.id);
    end
    nchecks++;
    if (rsp_err !== e.err) begin
      nerrors++;
      $display("FAIL rsp_err id=%0d: %b, required %b", e.id, rsp_err, e.err);
    end
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      nchecks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_id !== e.id || req_ready !== 1'b0) begin
        nerrors++;
        $display("FAIL rsp_hold cycle %0d: valid=%b rdata=%h id=%0d req_ready=%b, required 1/%h/%0d/0",
                 i, rsp_valid, rsp_rdata, rsp_id, req_ready, e.rdata, e.id);
      end
    end
    nchecks++;
    if (req_ready !== 1'b0) begin
      nerrors++;
      $display("FAIL req_ready_in_resp: %b, required 0", req_ready);
    end
    rsp_ready = 1'b1;
    hs = cyc;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    nchecks++;
    if (rsp_valid !== 1'b0) begin
      nerrors++;
      $display("FAIL rsp_drop: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic txn(input logic we, input logic size, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [3:0] id,
                     output logic [63:0] rd, output logic er);
    int acc, hs;
    send(we, size, addr, wdata, id, acc);
    recv(0, hs, rd, er);
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    nchecks++;
    if (act !== req) begin
      nerrors++;
      $display("FAIL %s: %h, required %h", name, act, req);
    end
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst3 = 1'b1; rst0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b0; rst3 = 1'b0; rst0 = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_val($sformatf("reset_req_ready[%0d]", s), 64'(req_ready), 64'd1);
      check_val($sformatf("reset_rsp_valid[%0d]", s), 64'(rsp_valid), 64'd0);
      check_val($sformatf("reset_rsp_rdata[%0d]", s), rsp_rdata, 64'd0);
      check_val($sformatf("reset_rsp_id[%0d]", s), 64'(rsp_id), 64'd0);
      check_val($sformatf("reset_rsp_err[%0d]", s), 64'(rsp_err), 64'd0);
    end
    sel = 0; #1;
  endtask

  task automatic test_fetch();
    logic [63:0] rd; logic er;
    sel = 0;
    txn(1'b1, 1'b0, 64'h2000, 64'hDEADBEEF_12345678, 4'd1, rd, er);
    txn(1'b0, 1'b0, 64'h2000, 64'h0, 4'd3, rd, er);
    check_val("fetch_rdata", rd, 64'h0000_0000_1234_5678);
    check_val("fetch_err", 64'(er), 64'd0);
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic er;
    sel = 0;
    txn(1'b1, 1'b1, 64'h1000, 64'h01020304_05060708, 4'd5, rd, er);
    check_val("store_rdata", rd, 64'd0);
    check_val("store_err", 64'(er), 64'd0);
    txn(1'b0, 1'b1, 64'h1000, 64'h0, 4'd6, rd, er);
    check_val("load_dword", rd, 64'h01020304_05060708);
    txn(1'b0, 1'b0, 64'h1004, 64'h0, 4'd7, rd, er);
    check_val("load_word_hi", rd, 64'h0000_0000_0102_0304);
  endtask

  task automatic test_bounds();
    logic [63:0] rd; logic er;
    sel = 0;
    txn(1'b1, 1'b1, 64'd524280, 64'hA1A2A3A4_A5A6A7A8, 4'd8, rd, er);
    check_val("top_store_err", 64'(er), 64'd0);
    txn(1'b0, 1'b1, 64'd524281, 64'h0, 4'd9, rd, er);
    check_val("over_read_err", 64'(er), 64'd1);
    check_val("over_read_rdata", rd, 64'd0);
    txn(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'd10, rd, er);
    check_val("wrap_read_err", 64'(er), 64'd1);
    txn(1'b1, 1'b1, 64'd524284, 64'h55555555_55555555, 4'd11, rd, er);
    check_val("over_store_err", 64'(er), 64'd1);
    txn(1'b0, 1'b1, 64'd524280, 64'h0, 4'd12, rd, er);
    check_val("top_unchanged", rd, 64'hA1A2A3A4_A5A6A7A8);
    txn(1'b0, 1'b0, 64'd524284, 64'h0, 4'd13, rd, er);
    check_val("top_word_read", rd, 64'h0000_0000_A1A2_A3A4);
    check_val("top_word_err", 64'(er), 64'd0);
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er;
    int acc, acc2, hs;
    sel = 0;
    send(1'b0, 1'b1, 64'h1000, 64'h0, 4'd14, acc);
    // Leave the next request pending while the response is stalled.
    req_we = 1'b0; req_size = 1'b0; req_addr = 64'h2000; req_wdata = '0; req_id = 4'd15;
    req_valid = 1'b1;
    recv(5, hs, rd, er);
    check_val("bp_rdata", rd, 64'h01020304_05060708);
    send(1'b0, 1'b0, 64'h2000, 64'h0, 4'd15, acc2);
    nchecks++;
    if (acc2 != hs + 1) begin
      nerrors++;
      $display("FAIL bp_pending_accept: cycle %0d, required %0d", acc2, hs + 1);
    end
    recv(0, hs, rd, er);
    check_val("bp_second_rdata", rd, 64'h0000_0000_1234_5678);
  endtask

  task automatic test_reset_mid_store();
    logic [63:0] rd; logic er;
    logic        bad;
    sel = 1;
    txn(1'b1, 1'b1, 64'h3000, 64'h11112222_33334444, 4'd1, rd, er);
    req_we = 1'b1; req_size = 1'b1; req_addr = 64'h3000; req_wdata = 64'h99998888_77776666;
    req_id = 4'd2; req_valid = 1'b1;
    check_val("rms_ready_before", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst3 = 1'b1; #1;
    check_val("rms_async_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(posedge clk); #1;
    check_val("rms_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rms_req_ready", 64'(req_ready), 64'd1);
    bad = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) bad = 1'b1; end
    check_val("rms_no_late_rsp", 64'(bad), 64'd0);
    txn(1'b0, 1'b1, 64'h3000, 64'h0, 4'd3, rd, er);
    check_val("rms_mem_unchanged", rd, 64'h11112222_33334444);
  endtask

  task automatic test_back_to_back_lat0();
    logic [63:0] rd; logic er;
    logic [63:0] addrs [4];
    logic        sizes [4];
    int          acc_c [4];
    int          n_acc, n_rsp;
    logic        acc_now;
    exp_t        e;
    sel = 2;
    txn(1'b1, 1'b1, 64'h100, 64'hCAFEF00D_0BADBEEF, 4'd1, rd, er);
    txn(1'b1, 1'b1, 64'h108, 64'h76543210_FEDCBA98, 4'd2, rd, er);
    addrs[0] = 64'h100; sizes[0] = 1'b1;
    addrs[1] = 64'h104; sizes[1] = 1'b0;
    addrs[2] = 64'h103; sizes[2] = 1'b1;
    addrs[3] = 64'h108; sizes[3] = 1'b1;
    n_acc = 0; n_rsp = 0;
    rsp_ready = 1'b1;
    req_we = 1'b0; req_wdata = '0;
    req_addr = addrs[0]; req_size = sizes[0]; req_id = 4'd8; req_valid = 1'b1;
    for (int c = 0; c < 40 && n_rsp < 4; c++) begin
      acc_now = req_valid && req_ready;
      if (acc_now) begin
        acc_c[n_acc] = cyc;
        sb.push_back(model_rsp(1'b0, req_size, req_addr, '0, req_id, cyc));
      end
      if (rsp_valid) begin
        nchecks++;
        if (sb.size() == 0) begin
          nerrors++;
          $display("FAIL b2b_unexpected_rsp: id=%0d, required no response", rsp_id);
        end else begin
          e = sb.pop_front();
          if (rsp_rdata !== e.rdata || rsp_id !== e.id || rsp_err !== e.err || cyc != e.acc + 1) begin
            nerrors++;
            $display("FAIL b2b_rsp %0d: rdata=%h id=%0d err=%b lat=%0d, required %h/%0d/%b/1",
                     n_rsp, rsp_rdata, rsp_id, rsp_err, cyc - e.acc, e.rdata, e.id, e.err);
          end
        end
        n_rsp++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        n_acc++;
        if (n_acc < 4) begin
          req_addr = addrs[n_acc]; req_size = sizes[n_acc]; req_id = 4'(8 + n_acc);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_val("b2b_rsp_count", 64'(n_rsp), 64'd4);
    if (n_acc == 4) begin
      for (int i = 1; i < 4; i++) begin
        check_val($sformatf("b2b_spacing[%0d]", i), 64'(acc_c[i] - acc_c[i-1]), 64'd2);
      end
    end else begin
      check_val("b2b_accept_count", 64'(n_acc), 64'd4);
    end
  endtask

  initial begin
    sel = 0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_id = '0;
    rst2 = 1'b1; rst3 = 1'b1; rst0 = 1'b1;
    test_reset();
    test_fetch();
    test_store_load();
    test_bounds();
    test_backpressure();
    test_reset_mid_store();
    test_back_to_back_lat0();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/tinker_mem_responder.md
Name: tinker_mem_responder

Overview:
- Memory-side responder for the Tinker core's memory interface: serves instruction fetches, 64-bit loads and 64-bit stores over a valid/ready request channel and a valid/ready response channel.
- Replaces the combinational unified memory array, so the core can be moved to a latency-tolerant load/store and fetch unit.
- Byte-addressed, little-endian, one outstanding request at a time, fixed programmable access latency.

Parameters:
- MEM_BYTES, 524288, size of the byte array; valid addresses are 0 .. MEM_BYTES-1.
- LATENCY, 2, cycles spent in BUSY before the access commits; 0 is legal.
- ID_W, 4, width of the request/response tag.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = read
- req_size  in  1  0 = 4-byte access (fetch), 1 = 8-byte access (load/store)
- req_addr  in  64  byte address of the lowest byte
- req_wdata  in  64  store data; bits [7:0] go to req_addr
- req_id  in  ID_W  tag echoed on the response
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_rdata  out  64  read data, zero-extended for 4-byte reads; 0 for stores and errors
- rsp_id  out  ID_W  tag of the request being answered
- rsp_err  out  1  address out of range

Behaviour:
- Reset, asynchronous:
  - state = IDLE; req_ready = 1 after release.
  - rsp_valid = 0, rsp_rdata = 0, rsp_id = 0, rsp_err = 0; latency counter = 0.
  - Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture we, size, addr, wdata and id.
  - If LATENCY == 0, go to RESP. Otherwise load the counter with LATENCY-1 and go to BUSY.
- BUSY:
  - req_ready = 0; the counter decrements each cycle.
  - When the counter reaches 0, commit the access on that clock edge and go to RESP.
- Commit:
  - nbytes = 4 if size = 0, else 8. The access is out of range if addr + nbytes - 1 >= MEM_BYTES, computed in 65 bits so wrap past 2^64 is also an error.
  - Out of range: no array write; rsp_err = 1; rsp_rdata = 0.
  - Read: rsp_rdata = {mem[addr+nbytes-1] .. mem[addr]}, upper 32 bits 0 when size = 0.
  - Store: writes mem[addr+k] = wdata[8k+7:8k] for k = 0..nbytes-1; rsp_rdata = 0.
  - Misaligned addresses are legal.
- RESP:
  - rsp_valid = 1; rsp_rdata, rsp_id and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE; rsp_valid drops the next cycle.
  - req_ready = 0 while in RESP.
- Throughput: at most one request per LATENCY+2 cycles when rsp_ready is held at 1.
- Read-after-write: a read accepted after a store's response handshake observes the stored data.
- Request inputs are ignored outside IDLE; the requester keeps req_valid asserted until accepted.
- Reset during BUSY abandons the access; a pending store is never committed. Reset during RESP drops the response.
- Store to the top of memory: addr = MEM_BYTES-8 with size 1 is in range; addr = MEM_BYTES-7 is an error.
- Simultaneous req_valid and a response handshake: the new request is not accepted in that cycle, because req_ready = 0 in RESP.

Decomposition:
- Shared package tinker_mem_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - size encodings SZ_WORD = 0, SZ_DWORD = 1;
  - default MEM_BYTES = 524288;
  - a request struct {we, size, addr, wdata, id}.
- Sub-module tinker_byte_ram holds the byte array with an 8-byte little-endian read port and a byte-enabled write port (enable mask 8'h0F or 8'hFF).
- The FSM, range check and response register stay in tinker_mem_responder.

Test Plan:
- Fetch, with LATENCY = 2 and the array preloaded so mem[0x2000..0x2003] = 78 56 34 12: read size 0 at addr 0x2000, id 3. Required: accepted in cycle 0, rsp_valid in cycle 3, rsp_rdata = 0x0000000012345678, rsp_id = 3, rsp_err = 0.
- Store then load: store size 1, addr 0x1000, wdata 0x0102030405060708. Required: response rdata = 0, err = 0. A following read size 1 at 0x1000 returns 0x0102030405060708, and a read size 0 at 0x1004 returns 0x01020304.
- Bounds with 8-byte accesses:
  - Store at 524280 → err = 0.
  - Read at 524281 → err = 1, rdata = 0.
  - Read at 0xFFFFFFFFFFFFFFFC → err = 1.
  - Store at 524284 → err = 1, and the bytes at 524284..524287 are unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid. Required: rsp_valid, rdata and id stay stable; req_ready = 0 throughout; a request that stayed pending is accepted only after the handshake plus one cycle.
- Reset mid-store: assert reset one cycle after accepting a store to 0x3000 with LATENCY = 3. Required: rsp_valid = 0, req_ready = 1 after release, and mem[0x3000..0x3007] is unchanged.
- LATENCY = 0: back-to-back reads with rsp_ready = 1. Required: each response arrives the cycle after acceptance, at one request per 2 cycles.
